axi_rd_arb2: RTL and testbench

Two-requester read arbiter that shares the single AXI read port (AR/R channels) of the on-chip SRAM slave between two AXI masters, e.g. instruction fetch (S0) and data load (S1). It runs one burst at a time with round-robin grant. It forwards the AR beat, then steers R beats back to the granted master until RLAST. The write channels are outside this block and connect directly.

---
 rtl/axi_rd_arb2_pkg.sv | 15 +
 rtl/axi_rd_arb2_rr.sv | 13 +
 rtl/gen_dffren.sv | 21 ++
 rtl/gen_rsffr.sv | 20 ++
 rtl/axi_rd_arb2.sv | 187 ++++++++++++++++++
 tb/tb_axi_rd_arb2.sv | 309 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/axi_rd_arb2_pkg.sv
// rtl/axi_rd_arb2_pkg.sv - shared constants for the two-requester AXI read arbiter
package axi_rd_arb2_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int BEAT_W = 8;

endpackage

// File: rtl/axi_rd_arb2_rr.sv
// rtl/axi_rd_arb2_rr.sv - combinational 2-way round-robin picker
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_rr_last,
  output logic       o_gnt,
  output logic       o_gnt_vld
);

  // On a tie the requester that was not served last wins.
  assign o_gnt     = (i_req == 2'b11) ? ~i_rr_last : i_req[1];
  assign o_gnt_vld = |i_req;

endmodule

// File: rtl/gen_dffren.sv
// rtl/gen_dffren.sv - D flop with enable and asynchronous active-low reset
module gen_dffren #(
  parameter int            W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= RST_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/gen_rsffr.sv
// rtl/gen_rsffr.sv - set/clear flop (set dominant) with asynchronous active-low reset
module gen_rsffr (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= 1'b0;
    end else if (i_set) begin
      o_q <= 1'b1;
    end else if (i_clr) begin
      o_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_rd_arb2.sv
// rtl/axi_rd_arb2.sv - shares one AXI read port (AR/R) between two masters,
// one burst at a time, round-robin grant.
module axi_rd_arb2
  import axi_rd_arb2_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 32
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [AW-1:0] S0_ARADDR,
  input  logic [7:0]    S0_ARLEN,
  input  logic [2:0]    S0_ARSIZE,
  input  logic [1:0]    S0_ARBURST,
  input  logic          S0_ARVALID,
  output logic          S0_ARREADY,
  output logic [DW-1:0] S0_RDATA,
  output logic [1:0]    S0_RRESP,
  output logic          S0_RLAST,
  output logic          S0_RVALID,
  input  logic          S0_RREADY,
  input  logic [AW-1:0] S1_ARADDR,
  input  logic [7:0]    S1_ARLEN,
  input  logic [2:0]    S1_ARSIZE,
  input  logic [1:0]    S1_ARBURST,
  input  logic          S1_ARVALID,
  output logic          S1_ARREADY,
  output logic [DW-1:0] S1_RDATA,
  output logic [1:0]    S1_RRESP,
  output logic          S1_RLAST,
  output logic          S1_RVALID,
  input  logic          S1_RREADY,
  output logic [AW-1:0] M_ARADDR,
  output logic [7:0]    M_ARLEN,
  output logic [2:0]    M_ARSIZE,
  output logic [1:0]    M_ARBURST,
  output logic          M_ARVALID,
  input  logic          M_ARREADY,
  input  logic [DW-1:0] M_RDATA,
  input  logic [1:0]    M_RRESP,
  input  logic          M_RLAST,
  input  logic          M_RVALID,
  output logic          M_RREADY
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_grant;
  logic              r_rr_last;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [BEAT_W-1:0] r_len_q;
  logic [AW-1:0]     r_araddr;
  logic [2:0]        r_arsize;
  logic [1:0]        r_arburst;
  logic              err_q;

  logic [1:0]        w_req;
  logic              w_gnt;
  logic              w_gnt_vld;
  logic              w_in_idle;
  logic              w_in_addr;
  logic              w_in_data;
  logic              w_latch;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_last_hs;
  logic              w_len_err;
  logic              w_sel_rready;
  logic [AW-1:0]     w_sel_araddr;
  logic [7:0]        w_sel_arlen;
  logic [2:0]        w_sel_arsize;
  logic [1:0]        w_sel_arburst;
  logic              w_cnt_en;
  logic [BEAT_W-1:0] w_cnt_d;

  assign w_req = {S1_ARVALID, S0_ARVALID};

  rr_arb2 u_rr_arb2 (
    .i_req     (w_req),
    .i_rr_last (r_rr_last),
    .o_gnt     (w_gnt),
    .o_gnt_vld (w_gnt_vld)
  );

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_in_addr = (r_state == ST_ADDR);
  assign w_in_data = (r_state == ST_DATA);

  assign w_sel_araddr  = w_gnt ? S1_ARADDR  : S0_ARADDR;
  assign w_sel_arlen   = w_gnt ? S1_ARLEN   : S0_ARLEN;
  assign w_sel_arsize  = w_gnt ? S1_ARSIZE  : S0_ARSIZE;
  assign w_sel_arburst = w_gnt ? S1_ARBURST : S0_ARBURST;
  assign w_sel_rready  = r_grant ? S1_RREADY : S0_RREADY;

  assign w_latch   = w_in_idle & w_gnt_vld;
  assign w_ar_hs   = w_in_addr & M_ARREADY;
  assign w_r_hs    = w_in_data & M_RVALID & w_sel_rready;
  assign w_last_hs = w_r_hs & M_RLAST;
  // RLAST still ends the burst; a disagreement with ARLEN is only recorded.
  assign w_len_err = w_r_hs & ((r_beat_cnt == r_len_q) != M_RLAST);

  assign w_cnt_en = w_ar_hs | w_r_hs;
  assign w_cnt_d  = w_ar_hs ? '0 : r_beat_cnt + 8'd1;

  gen_dffren #(.W(2), .RST_VAL(ST_IDLE)) u_state (
    .i_clk(CLK), .i_rst_n(RSTn), .i_en(1'b1), .i_d(w_state_nxt), .o_q(r_state)
  );

  gen_dffren #(.W(1), .RST_VAL(1'b0)) u_grant (
    .i_clk(CLK), .i_rst_n(RSTn), .i_en(w_latch), .i_d(w_gnt), .o_q(r_grant)
  );

  gen_dffren #(.W(1), .RST_VAL(1'b1)) u_rr_last (
    .i_clk(CLK), .i_rst_n(RSTn), .i_en(w_last_hs), .i_d(r_grant), .o_q(r_rr_last)
  );

  gen_dffren #(.W(BEAT_W), .RST_VAL('0)) u_len_q (
    .i_clk(CLK), .i_rst_n(RSTn), .i_en(w_latch), .i_d(w_sel_arlen), .o_q(r_len_q)
  );

  gen_dffren #(.W(BEAT_W), .RST_VAL('0)) u_beat_cnt (
    .i_clk(CLK), .i_rst_n(RSTn), .i_en(w_cnt_en), .i_d(w_cnt_d), .o_q(r_beat_cnt)
  );

  gen_dffren #(.W(AW + 5), .RST_VAL('0)) u_ar_payload (
    .i_clk(CLK), .i_rst_n(RSTn), .i_en(w_latch),
    .i_d({w_sel_araddr, w_sel_arsize, w_sel_arburst}),
    .o_q({r_araddr, r_arsize, r_arburst})
  );

  gen_rsffr u_err (
    .i_clk(CLK), .i_rst_n(RSTn), .i_set(w_len_err), .i_clr(1'b0), .o_q(err_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_gnt_vld) w_state_nxt = ST_ADDR;
      ST_ADDR: if (M_ARREADY) w_state_nxt = ST_DATA;
      ST_DATA: if (w_last_hs) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    M_ARVALID  = 1'b0;
    M_ARADDR   = '0;
    M_ARLEN    = '0;
    M_ARSIZE   = '0;
    M_ARBURST  = '0;
    M_RREADY   = 1'b0;
    S0_ARREADY = 1'b0;
    S1_ARREADY = 1'b0;
    S0_RVALID  = 1'b0;
    S0_RDATA   = '0;
    S0_RRESP   = '0;
    S0_RLAST   = 1'b0;
    S1_RVALID  = 1'b0;
    S1_RDATA   = '0;
    S1_RRESP   = '0;
    S1_RLAST   = 1'b0;
    if (w_in_addr) begin
      M_ARVALID  = 1'b1;
      M_ARADDR   = r_araddr;
      M_ARLEN    = r_len_q;
      M_ARSIZE   = r_arsize;
      M_ARBURST  = r_arburst;
      S0_ARREADY = M_ARREADY & ~r_grant;
      S1_ARREADY = M_ARREADY & r_grant;
    end
    if (w_in_data) begin
      M_RREADY = w_sel_rready;
      if (r_grant) begin
        S1_RVALID = M_RVALID;
        S1_RDATA  = M_RDATA;
        S1_RRESP  = M_RRESP;
        S1_RLAST  = M_RLAST;
      end else begin
        S0_RVALID = M_RVALID;
        S0_RDATA  = M_RDATA;
        S0_RRESP  = M_RRESP;
        S0_RLAST  = M_RLAST;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arb2.sv
// tb/tb_axi_rd_arb2.sv - self-checking bench for axi_rd_arb2
module tb_axi_rd_arb2;
  import axi_rd_arb2_pkg::*;

  localparam int DW = 64;
  localparam int AW = 32;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic [AW-1:0] S0_ARADDR, S1_ARADDR, M_ARADDR;
  logic [7:0]    S0_ARLEN, S1_ARLEN, M_ARLEN;
  logic [2:0]    S0_ARSIZE, S1_ARSIZE, M_ARSIZE;
  logic [1:0]    S0_ARBURST, S1_ARBURST, M_ARBURST;
  logic          S0_ARVALID, S1_ARVALID, S0_ARREADY, S1_ARREADY;
  logic [DW-1:0] S0_RDATA, S1_RDATA, M_RDATA;
  logic [1:0]    S0_RRESP, S1_RRESP, M_RRESP;
  logic          S0_RLAST, S1_RLAST, S0_RVALID, S1_RVALID, S0_RREADY, S1_RREADY;
  logic          M_ARVALID, M_ARREADY, M_RLAST, M_RVALID, M_RREADY;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] q_addr  [2];
  logic [7:0]    q_len   [2];
  logic [2:0]    q_size  [2];
  logic [1:0]    q_burst [2];
  logic          q_pend  [2];
  logic          rr      [2];
  logic          ref_rr_last;
  int            grant_log [$];

  always #5 CLK = ~CLK;

  assign S0_ARADDR  = q_addr[0];
  assign S0_ARLEN   = q_len[0];
  assign S0_ARSIZE  = q_size[0];
  assign S0_ARBURST = q_burst[0];
  assign S0_ARVALID = q_pend[0];
  assign S0_RREADY  = rr[0];
  assign S1_ARADDR  = q_addr[1];
  assign S1_ARLEN   = q_len[1];
  assign S1_ARSIZE  = q_size[1];
  assign S1_ARBURST = q_burst[1];
  assign S1_ARVALID = q_pend[1];
  assign S1_RREADY  = rr[1];

  axi_rd_arb2 #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARSIZE(S0_ARSIZE), .S0_ARBURST(S0_ARBURST),
    .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY), .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP),
    .S0_RLAST(S0_RLAST), .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARSIZE(S1_ARSIZE), .S1_ARBURST(S1_ARBURST),
    .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY), .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP),
    .S1_RLAST(S1_RLAST), .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
    .M_RLAST(M_RLAST), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic f_rvalid(input int x);
    return (x != 0) ? S1_RVALID : S0_RVALID;
  endfunction
  function automatic logic [DW-1:0] f_rdata(input int x);
    return (x != 0) ? S1_RDATA : S0_RDATA;
  endfunction
  function automatic logic [1:0] f_rresp(input int x);
    return (x != 0) ? S1_RRESP : S0_RRESP;
  endfunction
  function automatic logic f_rlast(input int x);
    return (x != 0) ? S1_RLAST : S0_RLAST;
  endfunction
  function automatic logic f_arready(input int x);
    return (x != 0) ? S1_ARREADY : S0_ARREADY;
  endfunction

  // Reference arbitration: lone requester wins, a tie goes to whoever was not served last.
  function automatic int model_pick();
    if (q_pend[0] && q_pend[1]) return ref_rr_last ? 0 : 1;
    return q_pend[1] ? 1 : 0;
  endfunction

  task automatic issue(input int x, input logic [AW-1:0] addr, input logic [7:0] len);
    q_addr[x]  = addr;
    q_len[x]   = len;
    q_size[x]  = 3'd3;
    q_burst[x] = BURST_INCR;
    q_pend[x]  = 1'b1;
  endtask

  task automatic issue_rand(input int x, input logic [7:0] len);
    q_addr[x]  = $urandom;
    q_len[x]   = len;
    q_size[x]  = 3'($urandom_range(0, 3));
    q_burst[x] = 2'($urandom_range(0, 1));
    q_pend[x]  = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {M_ARVALID, M_RREADY, S0_ARREADY, S1_ARREADY,
                        S0_RVALID, S1_RVALID, S0_RLAST, S1_RLAST}, 64'd0);
    chk({tag, "_ar"}, {M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST}, 64'd0);
    chk({tag, "_rd0"}, S0_RDATA, 64'd0);
    chk({tag, "_rd1"}, S1_RDATA, 64'd0);
    chk({tag, "_resp"}, {S0_RRESP, S1_RRESP}, 64'd0);
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    q_pend[0] = 1'b0; q_pend[1] = 1'b0;
    rr[0] = 1'b0; rr[1] = 1'b0;
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RLAST = 1'b0; M_RDATA = '0; M_RRESP = '0;
    repeat (2) @(posedge CLK);
    #2;
    RSTn = 1'b1;
    ref_rr_last = 1'b1;
  endtask

  // Acts as the SRAM slave for one burst. rmode: 0 ready always, 1 toggle, 2 random.
  // last_at < 0 puts RLAST on beat ARLEN; otherwise on beat last_at.
  task automatic serve(input int hold, input int rmode, input bit reissue, input int last_at);
    int g, o, waited, beats, lim, n_last;
    logic [AW-1:0] ea;
    logic [7:0] el;
    logic [2:0] es;
    logic [1:0] eb;
    logic [DW-1:0] d;
    logic [1:0] rs;
    logic ph;
    g  = model_pick();
    o  = 1 - g;
    ea = q_addr[g]; el = q_len[g]; es = q_size[g]; eb = q_burst[g];
    n_last = (last_at < 0) ? int'(el) : last_at;
    waited = 0;
    forever begin
      #1;
      if (M_ARVALID === 1'b1 || waited >= 8) break;
      chk("idle_arready", {S1_ARREADY, S0_ARREADY}, 64'd0);
      tick();
      waited++;
    end
    chk("ar_latency", waited, 64'd1);
    chk("araddr", M_ARADDR, ea);
    chk("arlen", M_ARLEN, el);
    chk("arsize_burst", {M_ARSIZE, M_ARBURST}, {es, eb});
    for (int h = 0; h < hold; h++) begin
      M_ARREADY = 1'b0;
      #1;
      chk("arvalid_hold", M_ARVALID, 64'd1);
      chk("araddr_hold", M_ARADDR, ea);
      chk("arlen_hold", M_ARLEN, el);
      chk("arready_early", {S1_ARREADY, S0_ARREADY}, 64'd0);
      tick();
    end
    M_ARREADY = 1'b1;
    #1;
    chk("arready_g", f_arready(g), 64'd1);
    chk("arready_o", f_arready(o), 64'd0);
    grant_log.push_back(S1_ARREADY ? 1 : 0);
    tick();
    M_ARREADY = 1'b0;
    q_pend[g] = 1'b0;
    if (reissue) issue_rand(g, el);
    beats = 0;
    lim = 0;
    ph = 1'b1;
    while (beats <= n_last && lim < 200) begin
      d  = {$urandom, $urandom};
      rs = 2'($urandom_range(0, 3));
      M_RVALID = ($urandom_range(0, 3) != 0);
      M_RDATA  = d;
      M_RRESP  = rs;
      M_RLAST  = (beats == n_last);
      case (rmode)
        0: rr[g] = 1'b1;
        1: begin rr[g] = ph; ph = ~ph; end
        default: rr[g] = 1'($urandom_range(0, 1));
      endcase
      rr[o] = 1'($urandom_range(0, 1));
      #1;
      chk("m_rready", M_RREADY, rr[g]);
      chk("rvalid_g", f_rvalid(g), M_RVALID);
      chk("other_quiet", {f_rvalid(o), f_rlast(o), f_rresp(o)}, 64'd0);
      chk("other_rdata", f_rdata(o), 64'd0);
      chk("ar_blocked", {M_ARVALID, S1_ARREADY, S0_ARREADY}, 64'd0);
      if (M_RVALID) begin
        chk("rdata", f_rdata(g), d);
        chk("rresp", f_rresp(g), rs);
        chk("rlast", f_rlast(g), (beats == n_last) ? 64'd1 : 64'd0);
      end
      if (M_RVALID && rr[g]) beats++;
      tick();
      lim++;
    end
    chk("beats", beats, n_last + 1);
    M_RVALID = 1'b0;
    M_RLAST  = 1'b0;
    rr[0] = 1'b0; rr[1] = 1'b0;
    ref_rr_last = g[0];
  endtask

  initial begin
    int base;
    q_addr[0] = '0; q_addr[1] = '0; q_len[0] = '0; q_len[1] = '0;
    q_size[0] = '0; q_size[1] = '0; q_burst[0] = '0; q_burst[1] = '0;
    q_pend[0] = 1'b0; q_pend[1] = 1'b0; rr[0] = 1'b0; rr[1] = 1'b0;
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RLAST = 1'b0; M_RDATA = '0; M_RRESP = '0;
    RSTn = 1'b0;
    ref_rr_last = 1'b1;
    #3;
    check_zero("reset");
    chk("reset_err", dut.err_q, 64'd0);
    do_reset();

    // S0 alone, ARLEN=3 INCR
    issue(0, 32'h8000_0000, 8'd3);
    serve(0, 0, 1'b0, -1);

    // Both on the same cycle after reset: S0 first, then S1
    do_reset();
    base = grant_log.size();
    issue(0, 32'h0000_1000, 8'd0);
    issue(1, 32'h0000_2000, 8'd0);
    serve(0, 0, 1'b0, -1);
    serve(0, 0, 1'b0, -1);
    chk("tie_first", grant_log[base], 64'd0);
    chk("tie_second", grant_log[base + 1], 64'd1);

    // Both held continuously for six bursts: strict alternation
    base = grant_log.size();
    issue_rand(0, 8'd1);
    issue_rand(1, 8'd1);
    for (int k = 0; k < 6; k++) serve(0, 2, (k < 4), -1);
    for (int k = 0; k < 6; k++) chk("alternate", grant_log[base + k], k % 2);

    // S1 ARLEN=7 with RREADY toggling every cycle
    issue_rand(1, 8'd7);
    serve(0, 1, 1'b0, -1);

    // Slave stalls AR for five cycles
    issue_rand(0, 8'd2);
    serve(5, 2, 1'b0, -1);

    // Random traffic
    for (int k = 0; k < 12; k++) begin
      for (int x = 0; x < 2; x++)
        if (!q_pend[x] && $urandom_range(0, 1) == 1) issue_rand(x, 8'($urandom_range(0, 4)));
      if (!q_pend[0] && !q_pend[1]) issue_rand(int'($urandom_range(0, 1)), 8'($urandom_range(0, 4)));
      serve(int'($urandom_range(0, 3)), 2, 1'b0, -1);
    end
    while (q_pend[0] || q_pend[1]) serve(0, 2, 1'b0, -1);
    chk("err_clean", dut.err_q, 64'd0);

    // Early RLAST: burst ends on RLAST and the error flag sticks
    issue(0, 32'h0000_4000, 8'd3);
    serve(0, 0, 1'b0, 1);
    chk("err_set", dut.err_q, 64'd1);
    tick();
    chk("err_sticky", dut.err_q, 64'd1);

    // Reset during beat 2 of an ARLEN=3 burst
    issue(0, 32'h0000_5000, 8'd3);
    tick();
    #1;
    chk("rst_arvalid", M_ARVALID, 64'd1);
    M_ARREADY = 1'b1;
    tick();
    M_ARREADY = 1'b0;
    q_pend[0] = 1'b0;
    rr[0] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      M_RVALID = 1'b1;
      M_RDATA = {$urandom, $urandom};
      tick();
    end
    M_RVALID = 1'b1;
    #1;
    chk("rst_beat2_live", S0_RVALID, 64'd1);
    RSTn = 1'b0;
    #1;
    check_zero("rst_async");
    M_RVALID = 1'b0;
    rr[0] = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RSTn = 1'b1;
    ref_rr_last = 1'b1;
    issue_rand(1, 8'd2);
    serve(1, 2, 1'b0, -1);
    chk("rst_err_clear", dut.err_q, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
